// File: rtl/tf_ctrl_pkg.sv
// Shared types and defaults for the frequency-meter timing controller.
// Holds the frame state encoding, default phase lengths and the frame-period helper.
package tf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_GAP1,
    ST_LOCK,
    ST_GAP2,
    ST_CLR,
    ST_TAIL
  } tf_state_t;

  localparam int TF_DEF_GATE_LEN = 8;
  localparam int TF_DEF_LOCK_DLY = 1;
  localparam int TF_DEF_CLR_DLY  = 3;
  localparam int TF_DEF_TAIL_LEN = 2;

  // Cycles from one GATE entry to the next in continuous mode.
  function automatic int tf_frame_period(input int gate_len, input int lock_dly,
                                         input int clr_dly, input int tail_len);
    return gate_len + lock_dly + clr_dly + tail_len + 2;
  endfunction

endpackage

// File: rtl/tf_phase_cnt.sv
// Loadable down-counter timing one controller phase.
// tc is registered and is high during the last cycle of the loaded duration.
module tf_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      tc  <= (load_val <= CNT_W'(1));
    end else begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      tc <= (cnt == CNT_W'(2));
    end
  end

endmodule

// File: rtl/tf_ctrl_seq.sv
// Frame sequencer: gate window, latch strobe and counter clear with configurable gaps.
// Define TF_CTRL_GATE_PROG_EN to add the runtime gate_len port.
module tf_ctrl_seq
  import tf_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int GATE_LEN = TF_DEF_GATE_LEN,
  parameter int LOCK_DLY = TF_DEF_LOCK_DLY,
  parameter int CLR_DLY  = TF_DEF_CLR_DLY,
  parameter int TAIL_LEN = TF_DEF_TAIL_LEN,
  parameter int FC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
`ifdef TF_CTRL_GATE_PROG_EN
  input  logic [CNT_W-1:0] gate_len,
`endif
  output logic             enb,
  output logic             lock,
  output logic             clr,
  output logic             busy,
  output logic             done,
  output logic [FC_W-1:0]  frame_cnt
);

  localparam int MAX_LEN = (2 ** CNT_W) - 1;

  if (GATE_LEN < 1 || GATE_LEN > MAX_LEN) begin : g_bad_gate_len
    $error("tf_ctrl_seq: GATE_LEN out of range");
  end
  if (LOCK_DLY < 1 || LOCK_DLY > MAX_LEN) begin : g_bad_lock_dly
    $error("tf_ctrl_seq: LOCK_DLY out of range");
  end
  if (CLR_DLY < 1 || CLR_DLY > MAX_LEN) begin : g_bad_clr_dly
    $error("tf_ctrl_seq: CLR_DLY out of range");
  end
  if (TAIL_LEN < 1 || TAIL_LEN > MAX_LEN) begin : g_bad_tail_len
    $error("tf_ctrl_seq: TAIL_LEN out of range");
  end

  tf_state_t        state, state_nxt;
  logic             stop_pend;
  logic             stop_eff;
  logic             tc;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] g_eff;

  // The counter load on GATE entry is the latch point for the gate length.
`ifdef TF_CTRL_GATE_PROG_EN
  assign g_eff = (gate_len == '0) ? CNT_W'(1) : gate_len;
`else
  assign g_eff = CNT_W'(GATE_LEN);
`endif

  assign stop_eff = stop_pend | stop;

  tf_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .tc      (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) stop_pend <= 1'b0;
      else if (stop)        stop_pend <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !stop) state_nxt = ST_GATE;
      ST_GATE: begin
        if (stop)    state_nxt = ST_CLR;
        else if (tc) state_nxt = ST_GAP1;
      end
      ST_GAP1: begin
        if (stop)    state_nxt = ST_CLR;
        else if (tc) state_nxt = ST_LOCK;
      end
      ST_LOCK: state_nxt = ST_GAP2;
      ST_GAP2: if (tc) state_nxt = ST_CLR;
      ST_CLR:  state_nxt = ST_TAIL;
      ST_TAIL: if (tc) state_nxt = (cont && !stop_eff) ? ST_GATE : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Every state entry is a change of state, so a change reloads the phase counter.
  always_comb begin
    load     = (state_nxt != state) && (state_nxt != ST_IDLE);
    load_val = CNT_W'(1);
    case (state_nxt)
      ST_GATE: load_val = g_eff;
      ST_GAP1: load_val = CNT_W'(LOCK_DLY);
      ST_GAP2: load_val = CNT_W'(CLR_DLY);
      ST_TAIL: load_val = CNT_W'(TAIL_LEN);
      default: load_val = CNT_W'(1);
    endcase
  end

  // Outputs are flops decoded from the next state, so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enb       <= 1'b0;
      lock      <= 1'b0;
      clr       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      enb  <= (state_nxt == ST_GATE);
      lock <= (state_nxt == ST_LOCK);
      clr  <= (state_nxt == ST_CLR);
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_TAIL) && (state_nxt == ST_IDLE);
      if (state_nxt == ST_LOCK) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

endmodule

// File: tb/tb_tf_ctrl_seq.sv
// Directed bench for tf_ctrl_seq with default parameters; output timing is captured
// per cycle into bit vectors and compared against hand-derived masks.
module tb_tf_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cont;
`ifdef TF_CTRL_GATE_PROG_EN
  logic [7:0]  gate_len;
`endif
  logic        enb;
  logic        lock;
  logic        clr;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          exp_fc = 0;
  logic [63:0] v_enb, v_lock, v_clr, v_busy, v_done;

  always #5 clk = ~clk;

  tf_ctrl_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .cont     (cont),
`ifdef TF_CTRL_GATE_PROG_EN
    .gate_len (gate_len),
`endif
    .enb      (enb),
    .lock     (lock),
    .clr      (clr),
    .busy     (busy),
    .done     (done),
    .frame_cnt(frame_cnt)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start from IDLE, then record ncyc cycles starting at cycle 0.
  // stop is high only during cycle stop_at; cont is high during cycles below cont_lim.
  task automatic run_frame(input int ncyc, input int stop_at, input int cont_lim);
    v_enb = '0; v_lock = '0; v_clr = '0; v_busy = '0; v_done = '0;
    stop  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      cont = (c < cont_lim);
      stop = (c == stop_at);
      #4;
      v_enb[c]  = enb;
      v_lock[c] = lock;
      v_clr[c]  = clr;
      v_busy[c] = busy;
      v_done[c] = done;
      @(posedge clk); #1;
    end
    stop = 1'b0;
    cont = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [63:0] e_enb, input logic [63:0] e_lock,
                           input logic [63:0] e_clr, input logic [63:0] e_busy,
                           input logic [63:0] e_done);
    chk_eq({tag, ".enb"},  v_enb,  e_enb);
    chk_eq({tag, ".lock"}, v_lock, e_lock);
    chk_eq({tag, ".clr"},  v_clr,  e_clr);
    chk_eq({tag, ".busy"}, v_busy, e_busy);
    chk_eq({tag, ".done"}, v_done, e_done);
    chk_eq({tag, ".fcnt"}, 64'(frame_cnt), 64'(exp_fc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
`ifdef TF_CTRL_GATE_PROG_EN
    gate_len = 8'd8;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset.outs", 64'({enb, lock, clr, busy, done}), 64'h0);
    chk_eq("reset.fcnt", 64'(frame_cnt), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single default frame: enb 0-7, lock 9, clr 13, busy 0-15, done 16.
    run_frame(20, -1, 0);
    exp_fc = 1;
    chk_frame("single", 64'hFF, 64'h200, 64'h2000, 64'hFFFF, 64'h1_0000);

    // Three back-to-back frames; cont drops before the third frame's last TAIL cycle.
    run_frame(52, -1, 40);
    exp_fc = 4;
    chk_frame("cont", 64'h0000_00FF_00FF_00FF, 64'h0000_0200_0200_0200,
              64'h0000_2000_2000_2000, 64'h0000_FFFF_FFFF_FFFF, 64'h0001_0000_0000_0000);

    // Abort during GATE cycle 3: CLR at 4, TAIL 5-6, done 7, no lock.
    run_frame(12, 3, 0);
    chk_frame("abort", 64'hF, 64'h0, 64'h10, 64'h7F, 64'h80);

    // Stop in LOCK with cont high: frame completes, no second frame.
    run_frame(20, 9, 20);
    exp_fc = 5;
    chk_frame("stop_pend", 64'hFF, 64'h200, 64'h2000, 64'hFFFF, 64'h1_0000);

`ifdef TF_CTRL_GATE_PROG_EN
    gate_len = 8'd3;
    run_frame(14, -1, 0);
    exp_fc = 6;
    chk_frame("glen3", 64'h7, 64'h10, 64'h100, 64'h7FF, 64'h800);

    gate_len = 8'd0;
    run_frame(12, -1, 0);
    exp_fc = 7;
    chk_frame("glen0", 64'h1, 64'h4, 64'h40, 64'h1FF, 64'h200);
    gate_len = 8'd8;
`endif

    // start and stop together in IDLE: nothing happens.
    v_busy = '0; v_done = '0; v_enb = '0;
    start = 1'b1;
    stop  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      v_busy[c] = busy;
      v_done[c] = done;
      v_enb[c]  = enb;
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    chk_eq("startstop.busy", v_busy, 64'h0);
    chk_eq("startstop.done", v_done, 64'h0);
    chk_eq("startstop.enb",  v_enb,  64'h0);

    // Reset during cycle 5 of a frame clears everything at once.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("midrst.pre_enb", 64'(enb), 64'h1);
    rst = 1'b1;
    #1;
    chk_eq("midrst.outs", 64'({enb, lock, clr, busy, done}), 64'h0);
    chk_eq("midrst.fcnt", 64'(frame_cnt), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(20, -1, 0);
    exp_fc = 1;
    chk_frame("post_rst", 64'hFF, 64'h200, 64'h2000, 64'hFFFF, 64'h1_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
